// File: rtl/sam_datapath_if.sv
// Strobe/status bundle between the shift-add multiplier controller (master)
// and its datapath (slave).
interface sam_datapath_if #(
  parameter int N = 4
);
  logic         load;
  logic         sh;
  logic         ad;
  logic         done;
  logic [N-1:0] mcand;
  logic [N-1:0] mplier;
  logic         m;
  logic         k;
  logic [2*N-1:0] product;
  logic         valid;

  modport master (
    output load, sh, ad, done, mcand, mplier,
    input  m, k, product, valid
  );

  modport slave (
    input  load, sh, ad, done, mcand, mplier,
    output m, k, product, valid
  );
endinterface

// File: rtl/sam_datapath.sv
// Shift-add multiplier datapath: accumulator/multiplier register, bit counter, product output.
// Optional macro SAM_PRODUCT_HOLD_EN: registers product_o on done instead of showing ACC live.
module sam_datapath #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  sam_datapath_if.slave  bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [2*N:0]  acc_reg, acc_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [N:0]    sum;
  logic          valid_reg;

  // Full N+1-bit add of the multiplicand into the upper half; carry lands in ACC[2N].
  assign sum     = {1'b0, acc_reg[2*N-1:N]} + {1'b0, bus.mcand};
  // Explicit wrap keeps the counter modulo N for non-power-of-two widths.
  assign cnt_inc = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);

  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    if (bus.load) begin
      acc_next = {{(N+1){1'b0}}, bus.mplier};
      cnt_next = '0;
    end else if (bus.ad && bus.sh) begin
      acc_next = {1'b0, sum, acc_reg[N-1:1]};
      cnt_next = cnt_inc;
    end else if (bus.ad) begin
      acc_next = {sum, acc_reg[N-1:0]};
    end else if (bus.sh) begin
      acc_next = {1'b0, acc_reg[2*N:1]};
      cnt_next = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      valid_reg <= bus.done;
    end
  end

  assign bus.m     = acc_reg[0];
  assign bus.k     = (cnt_reg == CNT_LAST);
  assign bus.valid = valid_reg;

`ifdef SAM_PRODUCT_HOLD_EN
  logic [2*N-1:0] product_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_reg <= '0;
    end else if (bus.done) begin
      product_reg <= acc_reg[2*N-1:0];
    end
  end

  assign bus.product = product_reg;
`else
  assign bus.product = acc_reg[2*N-1:0];
`endif

endmodule

// File: tb/tb_sam_datapath.sv
// Scoreboard bench for sam_datapath (N=4): products queued on done, checked on valid.
module tb_sam_datapath;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [2*N-1:0] exp_q[$];

  sam_datapath_if #(.N(N)) bus ();

  sam_datapath #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (!rst && bus.valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL product_unexpected actual=%0d required=no_valid", bus.product);
      end else begin
        logic [2*N-1:0] e;
        e = exp_q.pop_front();
        if (bus.product !== e) begin
          errors++;
          $display("FAIL product actual=%0d required=%0d", bus.product, e);
        end else begin
          $display("ok   product = %0d", bus.product);
        end
      end
    end
  end

  // Apply one cycle of strobes; returns 1 time unit after the sampling edge.
  task automatic drive(input logic l, input logic s, input logic a, input logic d);
    bus.load = l; bus.sh = s; bus.ad = a; bus.done = d;
    @(posedge clk);
    #1;
    bus.load = 1'b0; bus.sh = 1'b0; bus.ad = 1'b0; bus.done = 1'b0;
  endtask

  task automatic load_ops(input int a, input int b);
    bus.mcand  = N'(a);
    bus.mplier = N'(b);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // One multiplier bit: fused ad+sh or separate ad then sh when M is set.
  task automatic step_bit(input int i, input bit fused);
    chk($sformatf("k_before_step%0d", i), 32'(bus.k), 32'(i == N - 1));
    if (bus.m) begin
      if (fused) drive(1'b0, 1'b1, 1'b1, 1'b0);
      else begin
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end else begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic finish_mul(input int p);
    exp_q.push_back((2*N)'(p));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("valid_after_done", 32'(bus.valid), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("valid_single_pulse", 32'(bus.valid), 32'd0);
  endtask

  task automatic mul(input int a, input int b, input bit fused);
    load_ops(a, b);
    for (int i = 0; i < N; i++) step_bit(i, fused);
    finish_mul(a * b);
  endtask

  initial begin
    bus.load = 1'b0; bus.sh = 1'b0; bus.ad = 1'b0; bus.done = 1'b0;
    bus.mcand = '0; bus.mplier = '0;
    #2;
    chk("reset_product", 32'(bus.product), 32'd0);
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_m", 32'(bus.m), 32'd0);
    chk("reset_k", 32'(bus.k), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // load wins over ad/sh in the same cycle
    bus.mcand = 4'd13; bus.mplier = 4'd11;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("load_prio_m", 32'(bus.m), 32'd1);
    chk("load_prio_k", 32'(bus.k), 32'd0);
`ifndef SAM_PRODUCT_HOLD_EN
    chk("load_prio_acc", 32'(bus.product), 32'd11);
`endif

    mul(13, 11, 1'b1);

    // new load after done: held product vs live ACC
    load_ops(5, 3);
`ifdef SAM_PRODUCT_HOLD_EN
    chk("hold_after_load", 32'(bus.product), 32'd143);
`else
    chk("live_after_load", 32'(bus.product), 32'd3);
`endif

    mul(15, 15, 1'b1);

    // zero multiplier, shifts only; counter wraps after the 4th shift
    load_ops(9, 0);
    for (int i = 0; i < N; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("zero_m_shift%0d", i), 32'(bus.m), 32'd0);
      chk($sformatf("zero_k_shift%0d", i), 32'(bus.k), 32'(i == N - 2));
    end
    finish_mul(0);

    // async reset mid-multiply
    load_ops(7, 9);
    step_bit(0, 1'b0);
    step_bit(1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_product", 32'(bus.product), 32'd0);
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_m", 32'(bus.m), 32'd0);
    chk("midrst_k", 32'(bus.k), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mul(7, 9, 1'b0);

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
